// File: rtl/fpga_reset_sequencer.sv
// Board power/reset sequencer: synchronises lock and reset button, debounces the button,
// then brings up SD power, releases SoC reset and JTAG TRST in order.
//
// state      | meaning
// -----------+-------------------------------------------------------
// WAIT_LOCK  | waiting for clock lock and released button; all off
// SD_PWR     | SD card powered, SoC/TRST held for SD_PWR_CYCLES
// SOC_HOLD   | SD powered, SoC/TRST held for SOC_HOLD_CYCLES
// RUN        | everything released
// BTN_RST    | button pressed: SoC/TRST in reset, SD stays powered
module fpga_reset_sequencer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned SD_PWR_CYCLES   = 100000,
  parameter int unsigned SOC_HOLD_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH       = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       btn_reset_ni,
  output logic       soc_rst_no,
  output logic       jtag_trst_no,
  output logic       sd_pwr_en_no,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SD_PWR    = 3'd1,
    ST_SOC_HOLD  = 3'd2,
    ST_RUN       = 3'd3,
    ST_BTN_RST   = 3'd4
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DB_LAST   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SD_LAST   = CNT_WIDTH'(SD_PWR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(SOC_HOLD_CYCLES - 1);

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   lock_sync;
  logic                   btn_sync;

  logic                   btn_db_q, btn_db_d;
  logic [CNT_WIDTH-1:0]   db_cnt_q, db_cnt_d;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   soc_rst_q, soc_rst_d;
  logic                   trst_q, trst_d;
  logic                   sd_pwr_en_q, sd_pwr_en_d;

  assign lock_sync = lock_sync_q[SYNC_STAGES-1];
  assign btn_sync  = btn_sync_q[SYNC_STAGES-1];

  // Button synchroniser resets to "released" so a reset never looks like a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked_i};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_reset_ni};
    end
  end

  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (btn_sync != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_sync;
      end else begin
        db_cnt_d = db_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_db_q <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Delay counter only advances while staying in a timed state, so any transition clears it.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_sync && btn_db_q) state_d = ST_SD_PWR;
      end
      ST_SD_PWR: begin
        if (!lock_sync)             state_d = ST_WAIT_LOCK;
        else if (!btn_db_q)         state_d = ST_BTN_RST;
        else if (cnt_q == SD_LAST)  state_d = ST_SOC_HOLD;
        else                        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
      ST_SOC_HOLD: begin
        if (!lock_sync)             state_d = ST_WAIT_LOCK;
        else if (!btn_db_q)         state_d = ST_BTN_RST;
        else if (cnt_q == HOLD_LAST) state_d = ST_RUN;
        else                        cnt_d   = cnt_q + CNT_WIDTH'(1);
      end
      ST_RUN: begin
        if (!lock_sync)             state_d = ST_WAIT_LOCK;
        else if (!btn_db_q)         state_d = ST_BTN_RST;
      end
      ST_BTN_RST: begin
        if (!lock_sync)             state_d = ST_WAIT_LOCK;
        else if (btn_db_q)          state_d = ST_SOC_HOLD;
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    soc_rst_d   = (state_d == ST_RUN);
    trst_d      = (state_d == ST_RUN);
    sd_pwr_en_d = (state_d == ST_WAIT_LOCK);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      soc_rst_q   <= 1'b0;
      trst_q      <= 1'b0;
      sd_pwr_en_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      soc_rst_q   <= soc_rst_d;
      trst_q      <= trst_d;
      sd_pwr_en_q <= sd_pwr_en_d;
    end
  end

  assign soc_rst_no   = soc_rst_q;
  assign jtag_trst_no = trst_q;
  assign sd_pwr_en_no = sd_pwr_en_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes (edge index + values);
// a negedge monitor pops one entry on every observed change of the outputs.
module tb_fpga_reset_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       clk_locked_i = 1'b0;
  logic       btn_reset_ni = 1'b1;
  logic       soc_rst_no;
  logic       jtag_trst_no;
  logic       sd_pwr_en_no;
  logic [2:0] state_o;

  fpga_reset_sequencer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .SD_PWR_CYCLES   (8),
    .SOC_HOLD_CYCLES (5),
    .CNT_WIDTH       (20)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clk_locked_i (clk_locked_i),
    .btn_reset_ni (btn_reset_ni),
    .soc_rst_no   (soc_rst_no),
    .jtag_trst_no (jtag_trst_no),
    .sd_pwr_en_no (sd_pwr_en_no),
    .state_o      (state_o)
  );

  always #5 clk_i = ~clk_i;

  // cyc = number of rising edges seen; after edge k it reads k+1
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         edge_n;
    logic [5:0] val;   // {soc_rst_no, jtag_trst_no, sd_pwr_en_no, state_o}
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done = 1'b0;
  logic [5:0] prev = 6'b001_000;
  logic [5:0] cur;

  task automatic expect_ev(input int e, input logic soc, input logic trst,
                           input logic sd, input logic [2:0] st);
    ev_t ev;
    ev.edge_n = e;
    ev.val    = {soc, trst, sd, st};
    exp_q.push_back(ev);
  endtask

  // Return at the negedge before edge n so values driven now are sampled at edge n.
  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk_i);
  endtask

  always @(negedge clk_i) begin
    if (cyc >= 1 && !done) begin
      cur = {soc_rst_no, jtag_trst_no, sd_pwr_en_no, state_o};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: got %b at edge %0d, none expected", cur, cyc - 1);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.edge_n != cyc - 1 || e.val !== cur) begin
            errors++;
            $display("FAIL output_event: got %b at edge %0d, want %b at edge %0d",
                     cur, cyc - 1, e.val, e.edge_n);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    // 1: reset then power-up sequence
    expect_ev(12, 1'b0, 1'b0, 1'b0, 3'd1);
    expect_ev(20, 1'b0, 1'b0, 1'b0, 3'd2);
    expect_ev(25, 1'b1, 1'b1, 1'b0, 3'd3);
    at_cyc(1);
    checks++;
    if ({soc_rst_no, jtag_trst_no, sd_pwr_en_no, state_o} !== 6'b001_000) begin
      errors++;
      $display("FAIL reset_state: got %b want %b",
               {soc_rst_no, jtag_trst_no, sd_pwr_en_no, state_o}, 6'b001_000);
    end
    at_cyc(3);  rst_i = 1'b0;
    at_cyc(10); clk_locked_i = 1'b1;

    // 2: 3-cycle bounce in RUN
    at_cyc(30); btn_reset_ni = 1'b0;
    at_cyc(33); btn_reset_ni = 1'b1;
    at_cyc(35);
    checks++;
    if (dut.db_cnt_q !== 20'd3) begin
      errors++;
      $display("FAIL bounce_count_peak: got %0d want 3", dut.db_cnt_q);
    end
    at_cyc(37);
    checks++;
    if (dut.db_cnt_q !== 20'd0) begin
      errors++;
      $display("FAIL bounce_count_clear: got %0d want 0", dut.db_cnt_q);
    end

    // 3: long press, then 4: lock lost in the following SOC_HOLD and relock
    expect_ev(46, 1'b0, 1'b0, 1'b0, 3'd4);
    expect_ev(66, 1'b0, 1'b0, 1'b0, 3'd2);
    expect_ev(70, 1'b0, 1'b0, 1'b1, 3'd0);
    expect_ev(77, 1'b0, 1'b0, 1'b0, 3'd1);
    expect_ev(85, 1'b0, 1'b0, 1'b0, 3'd2);
    expect_ev(90, 1'b1, 1'b1, 1'b0, 3'd3);
    at_cyc(40); btn_reset_ni = 1'b0;
    at_cyc(60); btn_reset_ni = 1'b1;
    at_cyc(68); clk_locked_i = 1'b0;
    at_cyc(75); clk_locked_i = 1'b1;

    // 6: lock loss and debounced press land on the same edge (106)
    expect_ev(106, 1'b0, 1'b0, 1'b1, 3'd0);
    expect_ev(116, 1'b0, 1'b0, 1'b0, 3'd1);
    at_cyc(100); btn_reset_ni = 1'b0;
    at_cyc(104); clk_locked_i = 1'b0;
    at_cyc(110); btn_reset_ni = 1'b1;
    at_cyc(112); clk_locked_i = 1'b1;

    // 5: one-cycle rst_i pulse during SD_PWR
    expect_ev(120, 1'b0, 1'b0, 1'b1, 3'd0);
    expect_ev(123, 1'b0, 1'b0, 1'b0, 3'd1);
    expect_ev(131, 1'b0, 1'b0, 1'b0, 3'd2);
    expect_ev(136, 1'b1, 1'b1, 1'b0, 3'd3);
    at_cyc(120); rst_i = 1'b1;
    at_cyc(121); rst_i = 1'b0;

    at_cyc(150);
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, want 0 (next due edge %0d)",
               exp_q.size(), exp_q[0].edge_n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
